// File: rtl/dd_scan_driver.sv
// Multiplexed seven-segment scanner with double-buffered frame-synchronous updates,
// blank/blink masks, leading-zero suppression, anti-ghost guard and selectable pin polarity.
module dd_scan_driver #(
  parameter int                     NUM_DIGITS   = 8,
  parameter int                     COUNT_WIDTH  = 28,
  parameter logic [COUNT_WIDTH-1:0] SCAN_COUNT   = 28'h3000,
  parameter int                     GUARD        = 2,
  parameter int                     BLINK_FRAMES = 64,
  parameter bit                     ACTIVE_LOW   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dpMask,
  input  logic [NUM_DIGITS-1:0]     blankMask,
  input  logic [NUM_DIGITS-1:0]     blinkMask,
  input  logic                      lzsEn,
  output logic [7:0]                segOut,
  output logic [NUM_DIGITS-1:0]     gateOut,
  output logic                      frameDone,
  output logic                      pending
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [COUNT_WIDTH-1:0] CNT_LAST = SCAN_COUNT - COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] GUARD_C  = COUNT_WIDTH'(GUARD);
  localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0]       BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLK_W-1:0]        blk_cnt_q, blk_cnt_d;
  logic                    blk_phase_q, blk_phase_d;
  logic                    pending_q, pending_d;

  logic [4*NUM_DIGITS-1:0] stg_val_q, stg_val_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d;
  logic [NUM_DIGITS-1:0]   stg_blank_q, stg_blank_d;
  logic [NUM_DIGITS-1:0]   stg_blink_q, stg_blink_d;

  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   act_blink_q, act_blink_d;

  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   gate_q, gate_d;
  logic                    frame_done_q, frame_done_d;

  logic                    cnt_wrap;
  logic                    frame_end;
  logic [3:0]              nib;
  logic                    dp_bit;
  logic                    blank_bit;
  logic                    blink_bit;
  logic                    lz_hit;
  logic                    upper_zero;
  logic                    dark;
  logic                    in_guard;

  always_comb begin
    cnt_wrap  = (cnt_q == CNT_LAST);
    frame_end = cnt_wrap && (idx_q == IDX_LAST);

    cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    blk_cnt_d   = blk_cnt_q;
    blk_phase_d = blk_phase_q;
    if (frame_end) begin
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d   = '0;
        blk_phase_d = ~blk_phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
    end

    stg_val_d   = stg_val_q;
    stg_dp_d    = stg_dp_q;
    stg_blank_d = stg_blank_q;
    stg_blink_d = stg_blink_q;
    pending_d   = pending_q;
    if (load) begin
      stg_val_d   = value;
      stg_dp_d    = dpMask;
      stg_blank_d = blankMask;
      stg_blink_d = blinkMask;
      pending_d   = 1'b1;
    end

    // A load coinciding with the boundary bypasses staging so the newest data wins.
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    act_blink_d = act_blink_q;
    if (frame_end) begin
      if (load) begin
        act_val_d   = value;
        act_dp_d    = dpMask;
        act_blank_d = blankMask;
        act_blink_d = blinkMask;
      end else if (pending_q) begin
        act_val_d   = stg_val_q;
        act_dp_d    = stg_dp_q;
        act_blank_d = stg_blank_q;
        act_blink_d = stg_blink_q;
      end
      pending_d = 1'b0;
    end

    // Walk from the most significant digit down so upper_zero covers d..NUM_DIGITS-1.
    nib        = 4'h0;
    dp_bit     = 1'b0;
    blank_bit  = 1'b0;
    blink_bit  = 1'b0;
    lz_hit     = 1'b0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (act_val_q[4*i +: 4] == 4'h0);
      if (IDX_W'(i) == idx_q) begin
        nib       = act_val_q[4*i +: 4];
        dp_bit    = act_dp_q[i];
        blank_bit = act_blank_q[i];
        blink_bit = act_blink_q[i];
        lz_hit    = upper_zero && (i != 0);
      end
    end

    dark     = blank_bit || (blink_bit && blk_phase_q) || (lzsEn && lz_hit);
    in_guard = (GUARD > 0) && (cnt_q < GUARD_C);

    if (in_guard) begin
      gate_d = '0;
      seg_d  = 8'h00;
    end else begin
      gate_d = NUM_DIGITS'(1) << idx_q;
      seg_d  = dark ? 8'h00 : {dp_bit, font(nib)};
    end

    frame_done_d = frame_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      blk_cnt_q    <= '0;
      blk_phase_q  <= 1'b0;
      pending_q    <= 1'b0;
      stg_val_q    <= '0;
      stg_dp_q     <= '0;
      stg_blank_q  <= '0;
      stg_blink_q  <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      act_blink_q  <= '0;
      seg_q        <= 8'h00;
      gate_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      blk_cnt_q    <= blk_cnt_d;
      blk_phase_q  <= blk_phase_d;
      pending_q    <= pending_d;
      stg_val_q    <= stg_val_d;
      stg_dp_q     <= stg_dp_d;
      stg_blank_q  <= stg_blank_d;
      stg_blink_q  <= stg_blink_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      act_blink_q  <= act_blink_d;
      seg_q        <= seg_d;
      gate_q       <= gate_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign segOut    = seg_q ^ {8{ACTIVE_LOW}};
  assign gateOut   = gate_q ^ {NUM_DIGITS{ACTIVE_LOW}};
  assign frameDone = frame_done_q;
  assign pending   = pending_q;

endmodule

// File: doc/dd_scan_driver.md
# dd_scan_driver

Parametrised multiplexed seven-segment scanner that time-multiplexes `NUM_DIGITS` hex digits onto one shared segment bus and a per-digit gate bus. It sits between the memory-mapped display registers in the IO block and the board display pins. It adds the following to the fixed two-bank dynamic display:

- double-buffered frame-synchronous updates
- per-digit blank and blink masks
- leading-zero suppression
- anti-ghosting guard interval
- selectable output polarity

## Interface

**Parameters**
- `NUM_DIGITS`, 8: number of digits scanned; 2..16.
- `COUNT_WIDTH`, 28: width of the slot counter.
- `SCAN_COUNT`, 28'h3000: cycles per digit slot; ≥ `GUARD`+1.
- `GUARD`, 2: cycles at the start of each slot with all gates inactive; ≥ 0.
- `BLINK_FRAMES`, 64: frames per blink half-period; ≥ 1.
- `ACTIVE_LOW`, 1: 1 inverts both `segOut` and `gateOut` at the pins.

**Ports**
- `clk`  in  1: single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `load`  in  1: one-cycle strobe that stages `value`, `dpMask`, `blankMask` and `blinkMask`.
- `value`  in  4·`NUM_DIGITS`: hex nibbles; digit i is `value[4i+:4]`; digit 0 is rightmost.
- `dpMask`  in  `NUM_DIGITS`: decimal point per digit.
- `blankMask`  in  `NUM_DIGITS`: 1 forces digit dark.
- `blinkMask`  in  `NUM_DIGITS`: 1 blanks the digit during blink phase 1.
- `lzsEn`  in  1: leading-zero suppression enable; live, not staged.
- `segOut`  out  8: {dp,g,f,e,d,c,b,a}, registered.
- `gateOut`  out  `NUM_DIGITS`: one-hot digit enable, registered.
- `frameDone`  out  1: one-cycle pulse at each frame boundary, registered.
- `pending`  out  1: staged data not yet committed.

## Operation

**Registers**
- Staging set: value, dp, blank, blink.
- Active (shadow) set: value, dp, blank, blink.
- `pending` flag.
- Slot counter `cnt` (0..`SCAN_COUNT`-1).
- Digit index `idx` (0..`NUM_DIGITS`-1).
- Blink frame counter (0..`BLINK_FRAMES`-1).
- Blink phase bit.

**Scan**
- `cnt` increments every cycle.
- At `cnt`=`SCAN_COUNT`-1: `cnt` wraps to 0 and `idx` increments.
- At `idx`=`NUM_DIGITS`-1 together with a `cnt` wrap: `idx` wraps to 0. This is the frame boundary.
- Frame length is `NUM_DIGITS`·`SCAN_COUNT` cycles.

**Frame boundary**
- `frameDone` pulses.
- If `pending` is set, the staging set is copied to the active set and `pending` clears.
- The blink frame counter advances. When it wraps, the blink phase toggles.

**Load**
- `load` copies the inputs into the staging set and sets `pending`.
- A second load before the boundary overwrites the staging set; last load wins.
- `load` in the same cycle as a frame boundary: the newly loaded inputs are committed at that boundary, not the older staged set, and `pending` ends at 0.

**Digit visibility** (digit d = `idx`, using the active set)
- The digit is dark if any of these holds:
  - `blank[d]` is set;
  - `blink[d]` is set and the blink phase is 1;
  - suppression condition: `lzsEn`=1, d≠0, and every nibble from d through `NUM_DIGITS`-1 is 0.
- A dark digit drives the segment pattern 0x00, dp included.
- The gate stays active for a dark digit (uniform duty).

**Font** (internal active-high)
- 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
- 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- seg[7] = dp.

**Guard interval**
- While `cnt` < `GUARD`, the internal gate is all 0 and the internal seg is 0x00.
- Otherwise, internal gate = 1<<`idx`.

**Polarity**
- With `ACTIVE_LOW`=1, `segOut` and `gateOut` are the bitwise inverse of the internal values.

## Timing

**Latency**
- `segOut`, `gateOut` and `frameDone` are registered: they reflect the `cnt`/`idx` state of the previous cycle.
- Active-set change to visible pattern: 1 cycle after the commit.

**Reset values** (asynchronous assertion, synchronous release)
- `cnt`=0, `idx`=0.
- Blink counter 0, blink phase 0.
- Staging and active sets all 0; `pending`=0.
- `frameDone`=0.
- Internal gate and seg all 0. Pins therefore read all-ones when `ACTIVE_LOW`=1, all-zeros when `ACTIVE_LOW`=0.

**Reset mid-operation**
- Staged, uncommitted data is discarded.
- After release, the first slot starts at `idx` 0 with a full guard interval.

**Other rules**
- `frameDone` period is exactly `NUM_DIGITS`·`SCAN_COUNT` cycles.
- The first `frameDone` pulse after reset occurs on cycle `NUM_DIGITS`·`SCAN_COUNT`, counting the first post-release edge as cycle 1.
- `lzsEn` is sampled combinationally each cycle; a change is visible 1 cycle later, with no frame sync.

## Test plan

All scenarios use `NUM_DIGITS`=4, `SCAN_COUNT`=4, `GUARD`=1, `BLINK_FRAMES`=2, `ACTIVE_LOW`=0.

- **Reset and scan:** release reset, no load → `gateOut` sequence per slot is 0000, 0001×3, then 0000, 0010×3, etc.; `segOut` during visible cycles is 0x3F; `frameDone` every 16 cycles.
- **Double buffering:** load `value`=16'h12AF mid-frame → `pending`=1; old pattern held until the boundary; next frame shows digits 0..3 = 71, 77, 5B, 06; `pending` clears at the boundary.
- **Load on boundary:** load 16'h0001 in the boundary cycle while 16'h0002 is staged → 16'h0001 is displayed; `pending`=0 afterwards.
- **Leading-zero suppression:** `value`=16'h0050 with `lzsEn`=1 → digits 3 and 2 show 0x00, digit 1 shows 0x6D, digit 0 shows 0x3F. With `value`=0, digit 0 alone shows 0x3F.
- **Blink, blank and dp:** `blinkMask`=4'b0010, `blankMask`=4'b1000, `dpMask`=4'b0001 → digit 1 is dark for 2 frames and lit for 2 frames, alternating; digit 3 is always 0x00; digit 0 has seg[7]=1.
- **Reset mid-frame:** assert `rst` while `pending`=1 and `idx`=2 → all outputs go 0 immediately; after release the staged value is never shown and scanning restarts at `idx` 0.
